nlm_sdp_sram: RTL and testbench
===============================

NLM_SDP_SRAM -- requirements
Module: nlm_sdp_sram

Interface
REQ-001 Param DATA_WIDTH, default 16, data word width in bits.
REQ-002 Param ADDR_WIDTH, default 8, address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rstn  input  1  reset; synchronous, active-high (asserted = 1); one clock only.
REQ-005 wren_i  input  1  write enable from the line-store controller.
REQ-006 wraddr_i  input  ADDR_WIDTH  write address.
REQ-007 wrdata_i  input  DATA_WIDTH  write data.
REQ-008 rden_i  input  1  read request.
REQ-009 rdaddr_i  input  ADDR_WIDTH  read address.
REQ-010 rddata_o  output  DATA_WIDTH  read data, registered.
REQ-011 rdvalid_o  output  1  qualifies rddata_o for exactly one cycle per accepted read.
REQ-012 init_busy_o  output  1  high while the post-reset clear sweep runs.
REQ-013 req_err_o  output  1  one-cycle pulse when wren_i or rden_i is dropped during the sweep.

Function
REQ-014 The module SHALL have a two-state FSM: INIT and READY.
REQ-015 INIT SHALL write zero to address init_cnt each cycle, with init_cnt counting 0..DEPTH-1, then move to READY on the cycle after writing DEPTH-1.
REQ-016 init_busy_o SHALL be 1 throughout INIT (DEPTH cycles) and 0 in READY.
REQ-017 In INIT, external wren_i/rden_i SHALL be ignored; req_err_o SHALL pulse on the cycle after each such dropped request.
REQ-018 In READY, wren_i=1 SHALL write wrdata_i to wraddr_i at that clock edge.
REQ-019 In READY, rden_i=1 SHALL be accepted; data SHALL appear on rddata_o with rdvalid_o=1 exactly 2 cycles later (stage 1: array read register; stage 2: output register).
REQ-020 Back-to-back reads SHALL be accepted every cycle with full throughput; the pipeline has no stall or backpressure.
REQ-021 rddata_o SHALL hold its last value when rdvalid_o=0.
REQ-022 A same-cycle write and read to different addresses SHALL both complete independently.
REQ-023 Same-cycle write and read to the same address SHALL be resolved per REQ-028/029.
REQ-024 A read issued the cycle after a write to the same address SHALL return the new data.
REQ-025 Address arithmetic SHALL be unsigned; init_cnt is ADDR_WIDTH+1 bits wide so that the terminal count detects without wrapping.

Reset
REQ-026 rstn=1 SHALL force state=INIT, init_cnt=0, rddata_o=0, rdvalid_o=0, and both pipeline valid stages=0. init_busy_o SHALL be 1 on the first cycle after reset and req_err_o SHALL be 0.
REQ-027 Reset asserted mid-sweep or mid-read SHALL discard in-flight reads (no rdvalid_o pulse) and restart the sweep from address 0; array contents are not reset other than by the sweep.

Configuration
REQ-028 With NLM_SRAM_BYPASS_EN defined, a same-address, same-cycle read/write SHALL return wrdata_i (write-first).
REQ-029 Without NLM_SRAM_BYPASS_EN, the same collision SHALL return the old stored word (read-first); all other behaviour is identical.

Structure
REQ-030 Shared package nlm_pkg SHALL hold the FSM state encoding (INIT/READY), the default DATA_WIDTH/ADDR_WIDTH constants, and the read-latency constant (2).
REQ-031 The storage array SHALL be a sub-module, nlm_sdp_ram_core (one write port, one registered read port, no reset), so it can be swapped for a foundry macro.

Verification
REQ-032 Reset, then idle -> init_busy_o=1 for 256 cycles (ADDR_WIDTH=8), then 0. A full read sweep returns 0 at every address with rdvalid_o 2 cycles after each rden_i.
REQ-033 Write 0xA5A5 @0x10, next cycle read @0x10 -> rddata_o=0xA5A5, rdvalid_o=1 at read+2.
REQ-034 Old value 0x1111 @0x20; same cycle write 0x2222 @0x20 and read @0x20 -> 0x2222 with the macro defined, 0x1111 without.
REQ-035 Reads 0x00..0x07 issued in 8 consecutive cycles -> 8 consecutive rdvalid_o cycles, with data in order.
REQ-036 rden_i=1 at sweep cycle 5 -> req_err_o pulses at cycle 6 and no rdvalid_o follows.
REQ-037 Read @0x10 issued, reset asserted the next cycle -> no rdvalid_o; init_busy_o=1 again and the sweep restarts at address 0.

Source files
------------

// File: rtl/nlm_pkg.sv
// ---------------------------------------------------------------------------
// nlm_pkg
// Shared definitions for the NLM simple-dual-port line-store SRAM:
//   - default data and address widths
//   - read latency from an accepted rden_i to rdvalid_o
//   - FSM state encoding for the post-reset clear sweep
// ---------------------------------------------------------------------------
package nlm_pkg;

    localparam int NLM_DATA_WIDTH   = 16;
    localparam int NLM_ADDR_WIDTH   = 8;
    localparam int NLM_READ_LATENCY = 2;

    // INIT clears the array one word per cycle; READY serves the line-store
    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

endpackage

// File: rtl/nlm_sdp_ram_core.sv
// ---------------------------------------------------------------------------
// nlm_sdp_ram_core
// Plain storage array with one write port and one registered read port.
// No reset and no bypass logic, so it can be replaced by a foundry macro.
// On a same-address read/write the read returns the old word (read-first).
//
// Ports:
//   clk      in   clock, rising edge
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   re_i     in   read enable; rdata_o updates on the same edge
//   raddr_i  in   read address
//   rdata_o  out  registered read data
// ---------------------------------------------------------------------------
module nlm_sdp_ram_core #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Write and registered read share one edge; the non-blocking read of
    // mem_q naturally returns the pre-write word on an address collision.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/nlm_sdp_sram.sv
// ---------------------------------------------------------------------------
// nlm_sdp_sram
// Simple-dual-port SRAM for the NLM line store. After reset an INIT sweep
// writes zero to every address (one per cycle) before READY accepts traffic.
// Reads have a two-stage pipeline: array read register, then output register.
//
// Optional feature: define NLM_SRAM_BYPASS_EN for write-first behaviour on a
// same-cycle, same-address read/write; otherwise the old word is returned.
//
// Ports:
//   clk          in   clock, rising edge
//   rstn         in   synchronous reset, active HIGH despite the name
//   wren_i       in   write enable
//   wraddr_i     in   write address
//   wrdata_i     in   write data
//   rden_i       in   read request
//   rdaddr_i     in   read address
//   rddata_o     out  read data, held while rdvalid_o is low
//   rdvalid_o    out  one-cycle qualifier, two cycles after an accepted read
//   init_busy_o  out  high during the clear sweep
//   req_err_o    out  pulse the cycle after a request dropped during the sweep
// ---------------------------------------------------------------------------
module nlm_sdp_sram
    import nlm_pkg::*;
#(
    parameter int DATA_WIDTH = NLM_DATA_WIDTH,
    parameter int ADDR_WIDTH = NLM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wren_i,
    input  logic [ADDR_WIDTH-1:0] wraddr_i,
    input  logic [DATA_WIDTH-1:0] wrdata_i,
    input  logic                  rden_i,
    input  logic [ADDR_WIDTH-1:0] rdaddr_i,
    output logic [DATA_WIDTH-1:0] rddata_o,
    output logic                  rdvalid_o,
    output logic                  init_busy_o,
    output logic                  req_err_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);

    state_e                state_q;
    logic [ADDR_WIDTH:0]   initCnt_q;
    logic                  reqErr_q;

    logic                  ramWe;
    logic                  ramRe;
    logic [ADDR_WIDTH-1:0] ramWaddr;
    logic [DATA_WIDTH-1:0] ramWdata;
    logic [DATA_WIDTH-1:0] ramRdata;

    logic                  rdValid1_q;
    logic                  rdvalid_q;
    logic [DATA_WIDTH-1:0] rddata_q;
    logic [DATA_WIDTH-1:0] rddata_d;

    // Array port steering: the sweep owns the write port during INIT and
    // external requests are dropped; nothing touches the array while reset
    // is asserted so an in-flight read cannot restart the pipeline.
    always_comb begin
        ramWe    = 1'b0;
        ramRe    = 1'b0;
        ramWaddr = wraddr_i;
        ramWdata = wrdata_i;
        if (!rstn) begin
            if (state_q == INIT) begin
                ramWe    = 1'b1;
                ramWaddr = initCnt_q[ADDR_WIDTH-1:0];
                ramWdata = '0;
            end else begin
                ramWe = wren_i;
                ramRe = rden_i;
            end
        end
    end

    // Sweep FSM. The counter has one spare bit so reaching DEPTH never wraps
    // back onto address 0; the move to READY happens on the edge that writes
    // the last address, so INIT lasts exactly DEPTH cycles.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q   <= INIT;
            initCnt_q <= '0;
            reqErr_q  <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    reqErr_q  <= wren_i | rden_i;
                    initCnt_q <= initCnt_q + CNT_ONE;
                    if (initCnt_q == CNT_LAST) begin
                        state_q <= READY;
                    end
                end
                READY: begin
                    reqErr_q <= 1'b0;
                end
                default: begin
                    state_q  <= INIT;
                    reqErr_q <= 1'b0;
                end
            endcase
        end
    end

    nlm_sdp_ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_core (
        .clk     (clk),
        .we_i    (ramWe),
        .waddr_i (ramWaddr),
        .wdata_i (ramWdata),
        .re_i    (ramRe),
        .raddr_i (rdaddr_i),
        .rdata_o (ramRdata)
    );

`ifdef NLM_SRAM_BYPASS_EN
    logic                  collide1_q;
    logic [DATA_WIDTH-1:0] bypData_q;

    // Remember a same-address collision alongside stage 1 so stage 2 can
    // substitute the freshly written word for the array's old word.
    always_ff @(posedge clk) begin
        if (rstn) begin
            collide1_q <= 1'b0;
            bypData_q  <= '0;
        end else begin
            collide1_q <= ramRe & ramWe & (wraddr_i == rdaddr_i);
            bypData_q  <= wrdata_i;
        end
    end

    assign rddata_d = collide1_q ? bypData_q : ramRdata;
`else
    assign rddata_d = ramRdata;
`endif

    // Read pipeline: stage 1 valid tracks the array read register, stage 2
    // is the output register, which only loads when stage 1 holds a read.
    always_ff @(posedge clk) begin
        if (rstn) begin
            rdValid1_q <= 1'b0;
            rdvalid_q  <= 1'b0;
            rddata_q   <= '0;
        end else begin
            rdValid1_q <= ramRe;
            rdvalid_q  <= rdValid1_q;
            if (rdValid1_q) begin
                rddata_q <= rddata_d;
            end
        end
    end

    assign rddata_o    = rddata_q;
    assign rdvalid_o   = rdvalid_q;
    assign init_busy_o = (state_q == INIT);
    assign req_err_o   = reqErr_q;

endmodule

// File: tb/tb_nlm_sdp_sram.sv
// ---------------------------------------------------------------------------
// tb_nlm_sdp_sram
// Directed self-checking bench for nlm_sdp_sram with DATA_WIDTH=16,
// ADDR_WIDTH=8. Expected collision data follows NLM_SRAM_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_nlm_sdp_sram;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rstn;
    logic          wren_i;
    logic [AW-1:0] wraddr_i;
    logic [DW-1:0] wrdata_i;
    logic          rden_i;
    logic [AW-1:0] rdaddr_i;
    logic [DW-1:0] rddata_o;
    logic          rdvalid_o;
    logic          init_busy_o;
    logic          req_err_o;

    int checks   = 0;
    int failures = 0;
    int sweepCycles;
    int sweepValids;

`ifdef NLM_SRAM_BYPASS_EN
    localparam logic [15:0] COLLIDE_EXP = 16'h2222;
`else
    localparam logic [15:0] COLLIDE_EXP = 16'h1111;
`endif

    nlm_sdp_sram #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .wren_i      (wren_i),
        .wraddr_i    (wraddr_i),
        .wrdata_i    (wrdata_i),
        .rden_i      (rden_i),
        .rdaddr_i    (rdaddr_i),
        .rddata_o    (rddata_o),
        .rdvalid_o   (rdvalid_o),
        .init_busy_o (init_busy_o),
        .req_err_o   (req_err_o)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge
    task automatic applyStimulus(input logic we, input logic [AW-1:0] wa,
                                 input logic [DW-1:0] wd, input logic re,
                                 input logic [AW-1:0] ra);
        wren_i   = we;
        wraddr_i = wa;
        wrdata_i = wd;
        rden_i   = re;
        rdaddr_i = ra;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
    endtask

    // One reset cycle, released afterwards
    task automatic doReset();
        rstn = 1'b1;
        idle();
        rstn = 1'b0;
    endtask

    // Count remaining busy cycles (bounded) and any stray read valids
    task automatic waitSweep(output int cycles, output int valids);
        cycles = 0;
        valids = 0;
        while (init_busy_o && cycles < 400) begin
            cycles++;
            if (rdvalid_o) valids++;
            idle();
        end
    endtask

    // Single read with full latency and hold checks
    task automatic readWord(input string tag, input logic [AW-1:0] addr,
                            input logic [DW-1:0] expected);
        applyStimulus(1'b0, '0, '0, 1'b1, addr);
        checkOutput({tag, "_v1"}, 32'(rdvalid_o), 32'd0);
        idle();
        checkOutput({tag, "_v2"}, 32'(rdvalid_o), 32'd1);
        checkOutput({tag, "_data"}, 32'(rddata_o), 32'(expected));
        idle();
        checkOutput({tag, "_v3"}, 32'(rdvalid_o), 32'd0);
        checkOutput({tag, "_hold"}, 32'(rddata_o), 32'(expected));
    endtask

    initial begin
        rstn     = 1'b1;
        wren_i   = 1'b0;
        wraddr_i = '0;
        wrdata_i = '0;
        rden_i   = 1'b0;
        rdaddr_i = '0;

        // Reset state and first clear sweep
        doReset();
        checkOutput("rst_busy", 32'(init_busy_o), 32'd1);
        checkOutput("rst_vld", 32'(rdvalid_o), 32'd0);
        checkOutput("rst_data", 32'(rddata_o), 32'd0);
        checkOutput("rst_err", 32'(req_err_o), 32'd0);
        waitSweep(sweepCycles, sweepValids);
        checkOutput("sweep_len", 32'(sweepCycles), 32'd256);
        checkOutput("sweep_vlds", 32'(sweepValids), 32'd0);
        checkOutput("ready_busy", 32'(init_busy_o), 32'd0);

        // Full back-to-back read sweep, every word zero
        for (int j = 0; j <= DEPTH; j++) begin
            applyStimulus(1'b0, '0, '0, j < DEPTH, 8'(j));
            checkOutput("fullrd_vld", 32'(rdvalid_o), (j >= 1) ? 32'd1 : 32'd0);
            if (j >= 1) checkOutput("fullrd_data", 32'(rddata_o), 32'd0);
        end
        idle();
        checkOutput("fullrd_end", 32'(rdvalid_o), 32'd0);

        // Write then read the next cycle
        applyStimulus(1'b1, 8'h10, 16'hA5A5, 1'b0, '0);
        readWord("rdafterwr", 8'h10, 16'hA5A5);

        // Same-cycle collision
        applyStimulus(1'b1, 8'h20, 16'h1111, 1'b0, '0);
        applyStimulus(1'b1, 8'h20, 16'h2222, 1'b1, 8'h20);
        idle();
        checkOutput("collide_vld", 32'(rdvalid_o), 32'd1);
        checkOutput("collide_data", 32'(rddata_o), 32'(COLLIDE_EXP));
        readWord("collide_after", 8'h20, 16'h2222);

        // Same-cycle write and read to different addresses
        applyStimulus(1'b1, 8'h40, 16'h3333, 1'b1, 8'h10);
        idle();
        checkOutput("indep_vld", 32'(rdvalid_o), 32'd1);
        checkOutput("indep_data", 32'(rddata_o), 32'hA5A5);
        readWord("indep_wr", 8'h40, 16'h3333);

        // Burst of 8 consecutive reads
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(i), 16'h0100 + 16'(i), 1'b0, '0);
        for (int j = 0; j <= 8; j++) begin
            applyStimulus(1'b0, '0, '0, j < 8, 8'(j));
            checkOutput("burst_vld", 32'(rdvalid_o), (j >= 1) ? 32'd1 : 32'd0);
            if (j >= 1) checkOutput("burst_data", 32'(rddata_o), 32'h0100 + 32'(j - 1));
        end
        idle();
        checkOutput("burst_end", 32'(rdvalid_o), 32'd0);
        checkOutput("burst_hold", 32'(rddata_o), 32'h0107);

        // Reset right behind an accepted read
        applyStimulus(1'b0, '0, '0, 1'b1, 8'h10);
        doReset();
        checkOutput("midrd_vld", 32'(rdvalid_o), 32'd0);
        checkOutput("midrd_busy", 32'(init_busy_o), 32'd1);
        checkOutput("midrd_data", 32'(rddata_o), 32'd0);
        idle();
        checkOutput("midrd_vld2", 32'(rdvalid_o), 32'd0);
        waitSweep(sweepCycles, sweepValids);
        checkOutput("midrd_len", 32'(sweepCycles), 32'd255);
        checkOutput("midrd_vlds", 32'(sweepValids), 32'd0);
        readWord("clr10", 8'h10, 16'h0000);
        readWord("clr40", 8'h40, 16'h0000);
        readWord("clr05", 8'h05, 16'h0000);

        // Requests dropped during the sweep
        doReset();
        repeat (5) idle();
        applyStimulus(1'b0, '0, '0, 1'b1, 8'h10);
        checkOutput("drop_rd_err", 32'(req_err_o), 32'd1);
        idle();
        checkOutput("drop_rd_err0", 32'(req_err_o), 32'd0);
        checkOutput("drop_rd_vld", 32'(rdvalid_o), 32'd0);
        applyStimulus(1'b1, 8'h02, 16'hFFFF, 1'b0, '0);
        checkOutput("drop_wr_err", 32'(req_err_o), 32'd1);
        idle();
        checkOutput("drop_wr_err0", 32'(req_err_o), 32'd0);
        waitSweep(sweepCycles, sweepValids);
        checkOutput("drop_len", 32'(sweepCycles), 32'd247);
        checkOutput("drop_vlds", 32'(sweepValids), 32'd0);
        checkOutput("drop_err_rdy", 32'(req_err_o), 32'd0);
        readWord("drop_wr_ign", 8'h02, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
